// File: rtl/pu_accum_driver.sv
// pu_accum_driver: bus-side sequencer for one pu_accum instance.
// Turns operand jobs into load/init/neg strobes and returns a single result beat.
`default_nettype none

module pu_accum_driver #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int SIGN       = 0,
  parameter int OVERFLOW   = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_data,
  input  logic [ATTR_WIDTH-1:0] op_attr,
  input  logic                  op_neg,
  input  logic                  op_last,
  output logic                  signal_load,
  output logic                  signal_init,
  output logic                  signal_neg,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ATTR_WIDTH-1:0] attr_in,
  output logic                  signal_oe,
  input  logic [DATA_WIDTH-1:0] pu_data,
  input  logic [ATTR_WIDTH-1:0] pu_attr,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_sign,
  output logic                  res_overflow,
  output logic [CNT_WIDTH-1:0]  res_count,
  output logic                  busy
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_ACC  = 3'd1;
  localparam logic [2:0] c_WAIT = 3'd2;
  localparam logic [2:0] c_OE   = 3'd3;
  localparam logic [2:0] c_CAP  = 3'd4;
  localparam logic [2:0] c_RES  = 3'd5;

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_can_take;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_sign;
  logic                  r_res_overflow;
  logic [CNT_WIDTH-1:0]  r_res_count;
  logic                  w_unused_attr;

  // Only the sign and overflow attribute bits are reported back.
  assign w_unused_attr = ^pu_attr;

  // Gating with rst_n keeps the source from seeing ready while held in reset.
  assign w_can_take = (r_state == c_IDLE) || (r_state == c_ACC);
  assign op_ready   = rst_n && w_can_take;
  assign w_accept   = op_valid && op_ready;
  assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE,
      c_ACC:   if (w_accept) w_next = op_last ? c_WAIT : c_ACC;
      c_WAIT:  w_next = c_OE;
      c_OE:    w_next = c_CAP;
      c_CAP:   w_next = c_RES;
      c_RES:   if (res_ready) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    signal_load = 1'b0;
    signal_init = 1'b0;
    signal_neg  = 1'b0;
    data_in     = '0;
    attr_in     = '0;
    signal_oe   = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    if (w_accept) begin
      signal_load = 1'b1;
      signal_init = (r_state == c_IDLE);
      signal_neg  = op_neg;
      data_in     = op_data;
      attr_in     = op_attr;
    end
    signal_oe = (r_state == c_OE);
    res_valid = (r_state == c_RES);
    busy      = (r_state != c_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (r_state == c_IDLE) ? c_CNT_ONE : w_cnt_inc;
    end
  end

  // The PU output register is valid during CAP, one edge after the OE strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data     <= '0;
      r_res_sign     <= 1'b0;
      r_res_overflow <= 1'b0;
      r_res_count    <= '0;
    end else if (r_state == c_CAP) begin
      r_res_data     <= pu_data;
      r_res_sign     <= pu_attr[SIGN];
      r_res_overflow <= pu_attr[OVERFLOW];
      r_res_count    <= r_cnt;
    end
  end

  assign res_data     = r_res_data;
  assign res_sign     = r_res_sign;
  assign res_overflow = r_res_overflow;
  assign res_count    = r_res_count;

endmodule

`default_nettype wire

// File: tb/tb_pu_accum_driver.sv
// tb_pu_accum_driver: self-checking bench with a simple accumulator PU model
// and a job-level reference model for the expected result beat.
`default_nettype none

module tb_pu_accum_driver;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_data = '0;
  logic [AW-1:0] op_attr = '0;
  logic          op_neg = 1'b0;
  logic          op_last = 1'b0;
  logic          signal_load, signal_init, signal_neg, signal_oe;
  logic [DW-1:0] data_in;
  logic [AW-1:0] attr_in;
  logic [DW-1:0] pu_data;
  logic [AW-1:0] pu_attr;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_sign, res_overflow;
  logic [CW-1:0] res_count;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pu_accum_driver #(
    .DATA_WIDTH(DW), .ATTR_WIDTH(AW), .SIGN(0), .OVERFLOW(1), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_attr(op_attr),
    .op_neg(op_neg), .op_last(op_last),
    .signal_load(signal_load), .signal_init(signal_init), .signal_neg(signal_neg),
    .data_in(data_in), .attr_in(attr_in), .signal_oe(signal_oe),
    .pu_data(pu_data), .pu_attr(pu_attr),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_sign(res_sign), .res_overflow(res_overflow), .res_count(res_count),
    .busy(busy)
  );

  // Accumulator PU: wraps modulo 2^DW, ORs attributes over the job, sign from the sum.
  logic [DW-1:0] pu_acc;
  logic [AW-1:0] pu_acc_attr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pu_acc <= '0; pu_acc_attr <= '0; pu_data <= '0; pu_attr <= '0;
    end else begin
      if (signal_load) begin
        if (signal_init) begin
          pu_acc      <= signal_neg ? -data_in : data_in;
          pu_acc_attr <= attr_in;
        end else begin
          pu_acc      <= signal_neg ? pu_acc - data_in : pu_acc + data_in;
          pu_acc_attr <= pu_acc_attr | attr_in;
        end
      end
      if (signal_oe) begin
        pu_data <= pu_acc;
        pu_attr <= {pu_acc_attr[AW-1:1], pu_acc[DW-1]};
      end
    end
  end

  // Current job description and per-beat observations.
  logic [DW-1:0] jd[$];
  bit            jn[$];
  logic [AW-1:0] ja[$];
  int            jg[$];
  logic [DW-1:0] od[$];
  logic [AW-1:0] oa[$];
  bit            oi[$];

  function automatic void clear_job();
    jd.delete(); jn.delete(); ja.delete(); jg.delete();
  endfunction

  function automatic void add_op(int d, bit n, int a, int g);
    jd.push_back(DW'(d)); jn.push_back(n); ja.push_back(AW'(a)); jg.push_back(g);
  endfunction

  // Reference: signed sum of the job (negated operands subtracted), wrapped to DW bits.
  function automatic void model(output logic [DW-1:0] d, output logic s, output logic ov,
                                output int cnt);
    int sum;
    sum = 0; ov = 1'b0;
    for (int i = 0; i < jd.size(); i++) begin
      sum = jn[i] ? sum - int'($signed(jd[i])) : sum + int'($signed(jd[i]));
      if (ja[i][1]) ov = 1'b1;
    end
    d   = sum[DW-1:0];
    s   = d[DW-1];
    cnt = (jd.size() > 7) ? 7 : jd.size();
  endfunction

  task automatic send_job(output int gap_loads, output int oe_cnt, output int lat);
    int guard;
    bit done;
    od.delete(); oa.delete(); oi.delete();
    gap_loads = 0; oe_cnt = 0; lat = -1;
    for (int i = 0; i < jd.size(); i++) begin
      for (int g = 0; g < jg[i]; g++) begin
        @(negedge clk);
        op_valid = 1'b0; op_data = DW'($urandom); op_last = 1'($urandom);
        #1;
        if (signal_load) gap_loads++;
      end
      guard = 0; done = 1'b0;
      while (!done) begin
        @(negedge clk);
        op_valid = 1'b1; op_data = jd[i]; op_neg = jn[i]; op_attr = ja[i];
        op_last = (i == jd.size() - 1);
        #1;
        if (op_ready) begin
          done = 1'b1;
          od.push_back(data_in); oa.push_back(attr_in); oi.push_back(signal_init);
        end else if (++guard > 20) begin
          done = 1'b1;
        end
      end
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      op_valid = 1'b0; op_last = 1'b0; op_neg = 1'b0; op_attr = '0;
      #1;
      if (signal_oe) oe_cnt++;
      if (res_valid) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  task automatic release_result(int delay);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    op_valid = 1'b1; op_data = 8'h55; op_neg = 1'b1; op_attr = 4'hF;
    #1;
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL reset_op_ready got=%b want=0", op_ready); end
    total++; if ({signal_load, signal_init, signal_neg, signal_oe} !== 4'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=0000", {signal_load, signal_init, signal_neg, signal_oe}); end
    total++; if ({data_in, attr_in} !== '0) begin bad++; $display("FAIL reset_pu_drive got=%h want=0", {data_in, attr_in}); end
    total++; if ({res_valid, busy, res_sign, res_overflow} !== 4'b0 || res_data !== '0 || res_count !== '0) begin
      bad++; $display("FAIL reset_res got=%b/%h/%h want=0", {res_valid, busy, res_sign, res_overflow}, res_data, res_count); end
    @(negedge clk);
    op_valid = 1'b0; op_neg = 1'b0; op_attr = '0;
    rst_n = 1'b1;
    #1;
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL idle_op_ready got=%b want=1", op_ready); end
  endtask

  task automatic test_three_ops();
    int gl, oe, lat, cnt; logic [DW-1:0] d; logic s, ov;
    clear_job(); add_op(3, 0, 0, 0); add_op(5, 0, 0, 0); add_op(2, 1, 0, 0);
    send_job(gl, oe, lat); model(d, s, ov, cnt);
    total++; if (oi.size() != 3 || oi[0] !== 1'b1 || oi[1] !== 1'b0 || oi[2] !== 1'b0) begin
      bad++; $display("FAIL three_init beats=%0d got=%p want=1,0,0", oi.size(), oi); end
    total++; if (od.size() != 3 || od[0] !== 8'd3 || od[1] !== 8'd5 || od[2] !== 8'd2) begin
      bad++; $display("FAIL three_data_in got=%p want=3,5,2", od); end
    total++; if (res_data !== 8'd6 || res_data !== d) begin bad++; $display("FAIL three_res_data got=%0d want=6", res_data); end
    total++; if (res_count !== 3'd3) begin bad++; $display("FAIL three_count got=%0d want=3", res_count); end
    total++; if (lat != 3) begin bad++; $display("FAIL three_latency got=%0d want=3", lat); end
    release_result(0);
  endtask

  task automatic test_single_neg();
    int gl, oe, lat, cnt; logic [DW-1:0] d; logic s, ov;
    clear_job(); add_op(7, 1, 0, 0);
    send_job(gl, oe, lat); model(d, s, ov, cnt);
    total++; if (oi.size() != 1 || oi[0] !== 1'b1) begin bad++; $display("FAIL single_init got=%p want=1", oi); end
    total++; if (res_data !== 8'hF9 || res_data !== d) begin bad++; $display("FAIL single_data got=%h want=f9", res_data); end
    total++; if (res_count !== 3'd1 || res_sign !== 1'b1) begin
      bad++; $display("FAIL single_count_sign got=%0d/%b want=1/1", res_count, res_sign); end
    @(negedge clk); #1;
    total++; if (oe != 1 || signal_oe !== 1'b0) begin bad++; $display("FAIL single_oe got=%0d want=1", oe); end
    release_result(0);
  endtask

  task automatic test_gap();
    int gl, oe, lat, cnt; logic [DW-1:0] d; logic s, ov;
    clear_job(); add_op(10, 0, 0, 0); add_op(20, 0, 0, 2);
    send_job(gl, oe, lat); model(d, s, ov, cnt);
    total++; if (gl != 0) begin bad++; $display("FAIL gap_load got=%0d want=0", gl); end
    total++; if (res_data !== 8'd30 || res_count !== 3'd2) begin
      bad++; $display("FAIL gap_result got=%0d/%0d want=30/2", res_data, res_count); end
    release_result(0);
  endtask

  task automatic test_backpressure();
    int gl, oe, lat, cnt, errs; logic [DW-1:0] d, snap; logic s, ov;
    clear_job(); add_op($urandom_range(0, 255), 0, 0, 0); add_op($urandom_range(0, 255), 1, 0, 0);
    send_job(gl, oe, lat); model(d, s, ov, cnt);
    snap = res_data; errs = 0;
    total++; if (res_data !== d) begin bad++; $display("FAIL bp_data got=%h want=%h", res_data, d); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      op_valid = 1'b1; op_data = 8'hAA; res_ready = 1'b0;
      #1;
      if (res_data !== snap || res_valid !== 1'b1 || op_ready !== 1'b0 || busy !== 1'b1 ||
          signal_load !== 1'b0 || res_count !== 3'd2) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", errs); end
    op_valid = 1'b0;
    release_result(0);
    @(negedge clk); #1;
    total++; if (busy !== 1'b0 || op_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++; $display("FAIL bp_idle got=busy%b ready%b valid%b want=0/1/0", busy, op_ready, res_valid); end
  endtask

  task automatic test_abort();
    int gl, oe, lat, cnt, seen; logic [DW-1:0] d; logic s, ov;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      op_valid = 1'b1; op_data = 8'd9; op_neg = 1'b0; op_attr = '0; op_last = 1'b0;
    end
    @(negedge clk);
    op_valid = 1'b1; op_data = 8'd9; op_neg = 1'b1; op_last = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if ({op_ready, res_valid, busy, signal_load, signal_init, signal_neg, signal_oe} !== 7'b0) begin
      bad++; $display("FAIL abort_outputs got=%b want=0", {op_ready, res_valid, busy, signal_load, signal_init, signal_neg, signal_oe}); end
    @(negedge clk);
    op_valid = 1'b0; op_neg = 1'b0; rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (res_valid || busy) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_result got=%0d want=0", seen); end
    clear_job(); add_op(4, 0, 0, 0); add_op(4, 0, 0, 0);
    send_job(gl, oe, lat); model(d, s, ov, cnt);
    total++; if (oi.size() != 2 || oi[0] !== 1'b1 || res_data !== 8'd8 || res_count !== 3'd2) begin
      bad++; $display("FAIL abort_next_job got=%0d/%0d want=8/2", res_data, res_count); end
    release_result(0);
  endtask

  task automatic test_attr_overflow();
    int gl, oe, lat, cnt; logic [DW-1:0] d; logic s, ov;
    clear_job(); add_op(1, 0, 2, 0); add_op(1, 0, 0, 0);
    send_job(gl, oe, lat); model(d, s, ov, cnt);
    total++; if (oa.size() != 2 || oa[0] !== 4'h2 || oa[1] !== 4'h0) begin
      bad++; $display("FAIL attr_in got=%p want=2,0", oa); end
    total++; if (res_overflow !== 1'b1 || res_overflow !== ov || res_data !== 8'd2) begin
      bad++; $display("FAIL attr_ov_set got=%b/%0d want=1/2", res_overflow, res_data); end
    release_result(1);
    clear_job(); add_op(1, 0, 0, 0); add_op(1, 0, 0, 0);
    send_job(gl, oe, lat); model(d, s, ov, cnt);
    total++; if (res_overflow !== 1'b0) begin bad++; $display("FAIL attr_ov_clear got=%b want=0", res_overflow); end
    release_result(0);
  endtask

  task automatic test_random_jobs();
    int gl, oe, lat, cnt, n; logic [DW-1:0] d; logic s, ov;
    for (int j = 0; j < 8; j++) begin
      clear_job();
      n = (j == 0) ? 10 : $urandom_range(1, 10);
      for (int i = 0; i < n; i++)
        add_op($urandom_range(0, 255), 1'($urandom), $urandom_range(0, 1) * 2, $urandom_range(0, 2));
      send_job(gl, oe, lat); model(d, s, ov, cnt);
      total++; if (res_data !== d || res_sign !== s || res_overflow !== ov) begin
        bad++; $display("FAIL rand%0d_result got=%h/%b/%b want=%h/%b/%b", j, res_data, res_sign, res_overflow, d, s, ov); end
      total++; if (res_count !== CW'(cnt)) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", j, res_count, cnt); end
      total++; if (lat != 3 || oe != 1 || gl != 0 || oi.size() != n || oi[0] !== 1'b1) begin
        bad++; $display("FAIL rand%0d_timing got=lat%0d oe%0d gl%0d want=3/1/0", j, lat, oe, gl); end
      release_result($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_three_ops();
    test_single_neg();
    test_gap();
    test_backpressure();
    test_abort();
    test_attr_overflow();
    test_random_jobs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pu_accum_driver.md
# pu_accum_driver

Sequencer on the bus side of an accumulator processing unit. It takes a stream of signed operands with valid/ready handshake, turns each job into a load/init/neg command sequence for the PU, and issues the output-enable strobe at the right cycle. It captures the PU's registered result and attributes, then presents them as a single result beat with valid/ready handshake. It sits between a data source or FIFO and one `pu_accum` instance, and is used standalone in PU test harnesses.

## Interface
- DATA_WIDTH, 32, operand/result width; must match the PU.
- ATTR_WIDTH, 4, attribute width; must match the PU.
- SIGN, 0, attribute bit index of the sign flag.
- OVERFLOW, 1, attribute bit index of the overflow flag.
- CNT_WIDTH, 8, operand-counter width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operand beat offered.
- op_ready  out  1  driver can accept an operand.
- op_data  in  DATA_WIDTH  operand value.
- op_attr  in  ATTR_WIDTH  operand attributes; passed to the PU.
- op_neg  in  1  subtract this operand.
- op_last  in  1  last operand of the job.
- signal_load  out  1  PU load strobe.
- signal_init  out  1  PU init strobe; first operand of a job.
- signal_neg  out  1  PU negate strobe.
- data_in  out  DATA_WIDTH  operand to the PU.
- attr_in  out  ATTR_WIDTH  attributes to the PU.
- signal_oe  out  1  PU output enable.
- pu_data  in  DATA_WIDTH  PU data_out.
- pu_attr  in  ATTR_WIDTH  PU attr_out.
- res_valid  out  1  result beat valid.
- res_ready  in  1  result consumer ready.
- res_data  out  DATA_WIDTH  captured sum.
- res_sign  out  1  captured pu_attr[SIGN].
- res_overflow  out  1  captured pu_attr[OVERFLOW].
- res_count  out  CNT_WIDTH  operands in the job; saturates at all-ones.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ACC, WAIT, OE, CAP, RES.
- op_ready is 1 in IDLE and ACC only, and 0 while rst_n is low.
- Accept = op_valid && op_ready.
- PU drive is combinational from the current operand:
  - signal_load = accept.
  - signal_neg = accept && op_neg.
  - signal_init = accept && state==IDLE.
  - data_in = accept ? op_data : 0.
  - attr_in = accept ? op_attr : 0.
- IDLE: on accept, cnt <= 1. Go to WAIT if op_last, otherwise to ACC.
- ACC: on accept, cnt <= sat(cnt+1). Go to WAIT if op_last. With no accept, stay in ACC and drive no load; PU state holds.
- WAIT: one cycle, all PU strobes 0.
- OE: signal_oe = 1 for exactly one cycle.
- CAP: at the end of the cycle, register res_data <= pu_data, res_sign <= pu_attr[SIGN], res_overflow <= pu_attr[OVERFLOW], res_count <= cnt. Go to RES.
- RES: res_valid = 1. On res_valid && res_ready, go to IDLE. res_* stay stable until then.
- Arithmetic is done entirely in the PU. The driver never modifies data; negation is requested only through signal_neg.
- Reset: state IDLE, cnt 0, all res_* 0, res_valid 0, busy 0, signal_oe 0, all PU strobes 0. Asserting rst_n low mid-job aborts the job with no result beat. The next job starts with signal_init, which clears the PU accumulator.

## Timing
- Back-to-back operands are accepted one per cycle with no bubbles.
- Last operand accepted at edge E:
  - WAIT spans E..E+1.
  - signal_oe is high in E+1..E+2; the PU registers its output at E+2.
  - CAP spans E+2..E+3.
  - res_valid rises after E+3.
  - Latency from last accept to res_valid is 3 cycles.
- The earliest next accept is the cycle after the res handshake, since op_ready is 0 in RES.
- A single-operand job (first beat has op_last) goes IDLE -> WAIT with signal_init and signal_load both high.
- op_last is ignored unless the beat is accepted.

## Test plan
- DATA_WIDTH=8; operands 3, 5, 2(neg, last) back-to-back -> signal_init only on beat 1, res_data=6, res_count=3, res_valid exactly 3 cycles after the last accept.
- Single operand 7 with neg, last -> res_data=0xF9, res_count=1; signal_oe high exactly one cycle.
- Operands 10, 20(last) with op_valid low for 2 cycles between them -> signal_load low during the gap, res_data=30, res_count=2.
- res_ready held low 5 cycles after res_valid -> res_* stable, op_ready=0, busy=1; after the handshake, IDLE the next cycle and op_ready=1.
- rst_n pulsed low after 2 of 4 operands -> res_valid, op_ready and signal_* go to 0 immediately, with no result beat. A new job 4, 4(last) then gives res_data=8.
- One operand carrying op_attr[OVERFLOW]=1 in the job 1, 1(last) -> attr_in shows the bit on that beat, res_overflow=1; a repeat job with clean attributes -> res_overflow=0.
